mor1kx_store_buffer_cmb: RTL and testbench

- Parametrised successor store buffer for the LSU. Sits between store commit and the data bus write port.
- Register-based circular FIFO of pending stores. Its head entry is presented show-ahead.
- Optional write-combining: a new store merges into the youngest entry when both target the same word.
- Exposes a combinational address-conflict check so the LSU can stall loads that hit pending stores, plus an occupancy count.

---
 rtl/mor1kx_store_buffer_cmb.sv | 154 +++++++++++++++
 tb/tb_mor1kx_store_buffer_cmb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mor1kx_store_buffer_cmb.sv
// Store buffer between LSU store commit and the data bus write port.
// Circular register FIFO with show-ahead head, optional write-combining
// into the youngest entry, a combinational load/store overlap check and
// an occupancy count.
module mor1kx_store_buffer_cmb #(
  parameter int DEPTH_WIDTH          = 2,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_STORE_COMBINE = 1
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic [OPTION_OPERAND_WIDTH-1:0]   pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]   dat_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_i,
  input  logic                              atomic_i,
  input  logic                              write_i,

  output logic [OPTION_OPERAND_WIDTH-1:0]   pc_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]   dat_o,
  output logic [OPTION_OPERAND_WIDTH/8-1:0] bsel_o,
  output logic                              atomic_o,
  input  logic                              read_i,

  output logic                              full_o,
  output logic                              empty_o,
  output logic [DEPTH_WIDTH:0]              count_o,

  input  logic [OPTION_OPERAND_WIDTH-1:0]   chk_adr_i,
  input  logic [OPTION_OPERAND_WIDTH/8-1:0] chk_bsel_i,
  output logic                              chk_hit_o
);

  localparam int OW    = OPTION_OPERAND_WIDTH;
  localparam int BW    = OW / 8;
  localparam int LSB   = $clog2(BW);
  localparam int DEPTH = 1 << DEPTH_WIDTH;

  // Entry storage; deliberately not reset, validity comes from the pointers.
  logic [OW-1:0] pc_mem     [DEPTH];
  logic [OW-1:0] adr_mem    [DEPTH];
  logic [OW-1:0] dat_mem    [DEPTH];
  logic [BW-1:0] bsel_mem   [DEPTH];
  logic          atomic_mem [DEPTH];

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [DEPTH_WIDTH-1:0] tail_ptr;
  logic [DEPTH_WIDTH:0]   cnt;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          combine;
  logic          tail_word_match;
  logic [OW-1:0] merged_dat;
  logic [DEPTH-1:0] valid;
  logic [DEPTH_WIDTH-1:0] offs;

  assign tail_ptr = wr_ptr - DEPTH_WIDTH'(1);
  assign empty    = (cnt == '0);
  assign full     = (cnt == (DEPTH_WIDTH+1)'(DEPTH));

  assign tail_word_match = (adr_mem[tail_ptr][OW-1:LSB] == adr_i[OW-1:LSB]);

  // Merging into the tail is unsafe when that tail is the head leaving
  // this very cycle, and atomics must reach the bus as issued.
  assign combine = (OPTION_STORE_COMBINE != 0) && write_i && !empty &&
                   tail_word_match && !atomic_i && !atomic_mem[tail_ptr] &&
                   !(read_i && (cnt == (DEPTH_WIDTH+1)'(1)));

  assign pop  = read_i && !empty;
  // A write while full with no pop has nowhere to go and is dropped.
  assign push = write_i && !combine && (!full || read_i);

  // Byte-lane merge of the incoming store over the tail data.
  always_comb begin
    merged_dat = dat_mem[tail_ptr];
    for (int k = 0; k < BW; k++) begin
      if (bsel_i[k])
        merged_dat[8*k +: 8] = dat_i[8*k +: 8];
    end
  end

  // Entry payload: fresh writes at the write pointer, merges into the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]     <= pc_i;
      adr_mem[wr_ptr]    <= adr_i;
      dat_mem[wr_ptr]    <= dat_i;
      bsel_mem[wr_ptr]   <= bsel_i;
      atomic_mem[wr_ptr] <= atomic_i;
    end else if (combine) begin
      pc_mem[tail_ptr]   <= pc_i;
      dat_mem[tail_ptr]  <= merged_dat;
      bsel_mem[tail_ptr] <= bsel_mem[tail_ptr] | bsel_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
      if (pop)
        rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (DEPTH_WIDTH+1)'(1);
        2'b01:   cnt <= cnt - (DEPTH_WIDTH+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Slot i is valid when its distance from the read pointer is below count.
  always_comb begin
    valid = '0;
    offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs     = DEPTH_WIDTH'(i) - rd_ptr;
      valid[i] = ({1'b0, offs} < cnt);
    end
  end

  // Load overlap check against every valid entry, head included even when
  // it is popped this cycle; the store arriving this cycle is not seen.
  always_comb begin
    chk_hit_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] &&
          (adr_mem[i][OW-1:LSB] == chk_adr_i[OW-1:LSB]) &&
          ((bsel_mem[i] & chk_bsel_i) != '0))
        chk_hit_o = 1'b1;
    end
  end

  assign pc_o     = pc_mem[rd_ptr];
  assign adr_o    = adr_mem[rd_ptr];
  assign dat_o    = dat_mem[rd_ptr];
  assign bsel_o   = bsel_mem[rd_ptr];
  assign atomic_o = atomic_mem[rd_ptr];

  assign full_o  = full;
  assign empty_o = empty;
  assign count_o = cnt;

endmodule

// File: tb/tb_mor1kx_store_buffer_cmb.sv
// Bench for mor1kx_store_buffer_cmb: two instances (combining on / off)
// driven identically and compared each cycle against queue-based models.
module tb_mor1kx_store_buffer_cmb;

  localparam int DW    = 2;
  localparam int DEPTH = 1 << DW;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
    logic        atomic;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0, adr = '0, dat = '0, chk_adr = '0;
  logic [3:0]  bsel = '0, chk_bsel = '0;
  logic        atomic = 1'b0, write = 1'b0, read = 1'b0;

  logic [31:0] c_pc, c_adr, c_dat, n_pc, n_adr, n_dat;
  logic [3:0]  c_bsel, n_bsel;
  logic        c_atomic, c_full, c_empty, c_hit;
  logic        n_atomic, n_full, n_empty, n_hit;
  logic [DW:0] c_count, n_count;

  ent_t qc[$];
  ent_t qn[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mor1kx_store_buffer_cmb #(.DEPTH_WIDTH(DW), .OPTION_OPERAND_WIDTH(32),
                            .OPTION_STORE_COMBINE(1)) dut_c (
    .clk(clk), .rst(rst), .pc_i(pc), .adr_i(adr), .dat_i(dat), .bsel_i(bsel),
    .atomic_i(atomic), .write_i(write), .pc_o(c_pc), .adr_o(c_adr),
    .dat_o(c_dat), .bsel_o(c_bsel), .atomic_o(c_atomic), .read_i(read),
    .full_o(c_full), .empty_o(c_empty), .count_o(c_count),
    .chk_adr_i(chk_adr), .chk_bsel_i(chk_bsel), .chk_hit_o(c_hit));

  mor1kx_store_buffer_cmb #(.DEPTH_WIDTH(DW), .OPTION_OPERAND_WIDTH(32),
                            .OPTION_STORE_COMBINE(0)) dut_n (
    .clk(clk), .rst(rst), .pc_i(pc), .adr_i(adr), .dat_i(dat), .bsel_i(bsel),
    .atomic_i(atomic), .write_i(write), .pc_o(n_pc), .adr_o(n_adr),
    .dat_o(n_dat), .bsel_o(n_bsel), .atomic_o(n_atomic), .read_i(read),
    .full_o(n_full), .empty_o(n_empty), .count_o(n_count),
    .chk_adr_i(chk_adr), .chk_bsel_i(chk_bsel), .chk_hit_o(n_hit));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input ent_t q[$]);
    foreach (q[i])
      if (q[i].adr[31:2] == chk_adr[31:2] && (q[i].bsel & chk_bsel) != 4'h0)
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic cmp(input string tag, input ent_t q[$],
                     input logic [31:0] o_pc, input logic [31:0] o_adr,
                     input logic [31:0] o_dat, input logic [3:0] o_bsel,
                     input logic o_atomic, input logic o_full, input logic o_empty,
                     input logic [DW:0] o_count, input logic o_hit);
    check({tag, "_count"}, 64'(o_count), 64'(q.size()));
    check({tag, "_empty"}, 64'(o_empty), 64'(q.size() == 0));
    check({tag, "_full"},  64'(o_full),  64'(q.size() == DEPTH));
    check({tag, "_hit"},   64'(o_hit),   64'(model_hit(q)));
    if (q.size() > 0) begin
      check({tag, "_pc"},     64'(o_pc),     64'(q[0].pc));
      check({tag, "_adr"},    64'(o_adr),    64'(q[0].adr));
      check({tag, "_dat"},    64'(o_dat),    64'(q[0].dat));
      check({tag, "_bsel"},   64'(o_bsel),   64'(q[0].bsel));
      check({tag, "_atomic"}, 64'(o_atomic), 64'(q[0].atomic));
    end
  endtask

  // One clock: compare before the edge, then advance both models.
  task automatic tick();
    bit   cb_c, cb_n, ps_c, ps_n;
    int   sc, sn;
    ent_t e;
    ent_t ne;
    @(negedge clk);
    cmp("cmb", qc, c_pc, c_adr, c_dat, c_bsel, c_atomic, c_full, c_empty, c_count, c_hit);
    cmp("nocmb", qn, n_pc, n_adr, n_dat, n_bsel, n_atomic, n_full, n_empty, n_count, n_hit);
    @(posedge clk);
    sc = qc.size();
    sn = qn.size();
    cb_c = write && sc > 0 && qc[sc-1].adr[31:2] == adr[31:2] && !atomic &&
           !qc[sc-1].atomic && !(read && sc == 1);
    cb_n = 1'b0;
    ps_c = write && !cb_c && (sc < DEPTH || read);
    ps_n = write && !cb_n && (sn < DEPTH || read);
    ne.pc = pc; ne.adr = adr; ne.dat = dat; ne.bsel = bsel; ne.atomic = atomic;
    if (cb_c) begin
      e = qc[sc-1];
      for (int k = 0; k < 4; k++)
        if (bsel[k]) e.dat[8*k +: 8] = dat[8*k +: 8];
      e.bsel = e.bsel | bsel;
      e.pc   = pc;
      qc[sc-1] = e;
    end
    if (read && sc > 0) void'(qc.pop_front());
    if (read && sn > 0) void'(qn.pop_front());
    if (ps_c) qc.push_back(ne);
    if (ps_n) qn.push_back(ne);
    #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] p, input logic at);
    adr = a; dat = d; bsel = b; pc = p; atomic = at; write = 1'b1;
    tick();
    write = 1'b0; atomic = 1'b0;
  endtask

  task automatic do_pop();
    read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic drain();
    read = 1'b1;
    repeat (DEPTH) tick();
    read = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      write    = ($urandom_range(0, 99) < 55);
      read     = ($urandom_range(0, 99) < 45);
      adr      = 32'h40 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      dat      = $urandom;
      bsel     = 4'($urandom_range(1, 15));
      pc       = $urandom;
      atomic   = ($urandom_range(0, 7) == 0);
      chk_adr  = 32'h40 + $urandom_range(0, 15);
      chk_bsel = 4'($urandom_range(0, 15));
      tick();
    end
    write = 1'b0; read = 1'b0; atomic = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_adr = 32'h0; chk_bsel = 4'hF;
    #1;
    check("rst_count", 64'(c_count), 64'd0);
    check("rst_empty", 64'(c_empty), 64'd1);
    check("rst_full",  64'(c_full),  64'd0);
    check("rst_hit",   64'(c_hit),   64'd0);
    rst = 1'b0;
    qc.delete(); qn.delete();

    // FIFO ordering through distinct words
    do_push(32'h100, 32'h11, 4'hF, 32'h1000, 1'b0);
    do_push(32'h200, 32'h22, 4'hF, 32'h1004, 1'b0);
    do_push(32'h300, 32'h33, 4'hF, 32'h1008, 1'b0);
    check("fifo_count3", 64'(c_count), 64'd3);
    check("fifo_head0",  64'(c_adr),   64'h100);
    do_pop();
    check("fifo_head1",  64'(c_adr),   64'h200);
    do_pop();
    check("fifo_head2",  64'(c_adr),   64'h300);
    do_pop();
    check("fifo_empty",  64'(c_empty), 64'd1);

    // Byte-lane combining within one word
    do_push(32'h40, 32'h000000AA, 4'b0001, 32'h2000, 1'b0);
    do_push(32'h41, 32'h0000BB00, 4'b0010, 32'h2004, 1'b0);
    check("cmb_count",   64'(c_count), 64'd1);
    check("cmb_dat",     64'(c_dat),   64'h0000BBAA);
    check("cmb_bsel",    64'(c_bsel),  64'b0011);
    check("cmb_pc",      64'(c_pc),    64'h2004);
    check("cmb_adr",     64'(c_adr),   64'h40);
    check("nocmb_count", 64'(n_count), 64'd2);
    drain();

    // Atomic store never merges
    do_push(32'h40, 32'h1, 4'h1, 32'h3000, 1'b0);
    do_push(32'h40, 32'h2, 4'h2, 32'h3004, 1'b1);
    check("atom_count", 64'(c_count), 64'd2);
    do_pop();
    check("atom_head", 64'(c_atomic), 64'd1);
    drain();

    // Full, dropped write, write+read while full
    do_push(32'h100, 32'h1, 4'hF, 32'h4000, 1'b0);
    do_push(32'h200, 32'h2, 4'hF, 32'h4004, 1'b0);
    do_push(32'h300, 32'h3, 4'hF, 32'h4008, 1'b0);
    do_push(32'h400, 32'h4, 4'hF, 32'h400C, 1'b0);
    check("full_flag",  64'(c_full),  64'd1);
    do_push(32'h500, 32'h5, 4'hF, 32'h4010, 1'b0);
    check("drop_count", 64'(c_count), 64'd4);
    check("drop_head",  64'(c_adr),   64'h100);
    adr = 32'h600; dat = 32'h6; bsel = 4'hF; pc = 32'h4014; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    check("wr_rd_full_count", 64'(c_count), 64'd4);
    check("wr_rd_full_head",  64'(c_adr),   64'h200);
    repeat (3) do_pop();
    check("last_out", 64'(c_adr), 64'h600);
    do_pop();

    // Pointer wrap with steady push+pop
    do_push(32'h1000, 32'h0, 4'hF, 32'h5000, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      adr = 32'h1000 + 32'(i) * 32'h10; dat = 32'(i); bsel = 4'hF; pc = 32'h5000 + 32'(i);
      write = 1'b1; read = 1'b1;
      tick();
    end
    write = 1'b0; read = 1'b0;
    check("wrap_count", 64'(c_count), 64'd1);
    check("wrap_head",  64'(c_adr),   64'h10A0);
    do_pop();

    // Load overlap check
    do_push(32'h80, 32'hDEAD0000, 4'b1100, 32'h6000, 1'b0);
    chk_adr = 32'h80; chk_bsel = 4'b0011;
    #1;
    check("chk_miss_lane", 64'(c_hit), 64'd0);
    chk_adr = 32'h82; chk_bsel = 4'b0100;
    #1;
    check("chk_hit", 64'(c_hit), 64'd1);
    do_pop();
    check("chk_after_pop", 64'(c_hit), 64'd0);

    // Single entry popped while a matching store arrives: push, not merge
    do_push(32'h40, 32'h11, 4'b0001, 32'h7000, 1'b0);
    adr = 32'h40; dat = 32'h2200; bsel = 4'b0010; pc = 32'h7004; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    check("pop1_count", 64'(c_count), 64'd1);
    check("pop1_pc",    64'(c_pc),    64'h7004);
    check("pop1_bsel",  64'(c_bsel),  64'b0010);
    drain();

    random_cycles(1200);

    // Asynchronous reset mid-stream
    do_push(32'h44, 32'h1, 4'h1, 32'h8000, 1'b0);
    rst = 1'b1;
    #1;
    check("async_rst_empty", 64'(c_empty), 64'd1);
    check("async_rst_count", 64'(n_count), 64'd0);
    qc.delete(); qn.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    random_cycles(800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
